ir_rcv_nec_multi: RTL

// - Parametrised NEC-family IR decoder; successor to the fixed 27 MHz front-panel receiver.
// - Inputs: demodulated IR (idle high). Outputs: decoded address/command, repeat tracking and error reporting.
// - Adds clock-independent timing via a 10 us tick, a glitch filter, extended-NEC (16-bit address) mode,

---
 rtl/ir_rcv_nec_multi_pkg.sv | 36 +++
 rtl/ir_rcv_nec_multi_rx_filter.sv | 49 ++++
 rtl/ir_rcv_nec_multi.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ir_rcv_nec_multi_pkg.sv
// Shared definitions for the NEC-family IR receiver.
// Holds the FSM state encoding and the tick-count windows for each pulse type.
package ir_rcv_nec_multi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LO,
    LEAD_HI,
    BIT_LO,
    BIT_HI
  } irState_e;

  localparam int PHASE_W = 12;
  localparam int REL_W   = 14;

  // Inclusive windows in 10 us ticks, measured at the edge that ends each pulse
  localparam logic [PHASE_W-1:0] LEAD_LO_MIN = 12'd700;
  localparam logic [PHASE_W-1:0] LEAD_LO_MAX = 12'd1000;
  localparam logic [PHASE_W-1:0] LEAD_HI_MIN = 12'd370;
  localparam logic [PHASE_W-1:0] LEAD_HI_MAX = 12'd590;
  localparam logic [PHASE_W-1:0] RPT_HI_MIN  = 12'd170;
  localparam logic [PHASE_W-1:0] RPT_HI_MAX  = 12'd300;
  localparam logic [PHASE_W-1:0] BURST_MIN   = 12'd40;
  localparam logic [PHASE_W-1:0] BURST_MAX   = 12'd80;
  localparam logic [PHASE_W-1:0] SPACE0_MIN  = 12'd30;
  localparam logic [PHASE_W-1:0] SPACE0_MAX  = 12'd79;
  localparam logic [PHASE_W-1:0] SPACE1_MIN  = 12'd80;
  localparam logic [PHASE_W-1:0] SPACE1_MAX  = 12'd200;

  function automatic logic inWindow(input logic [PHASE_W-1:0] val,
                                    input logic [PHASE_W-1:0] lo,
                                    input logic [PHASE_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/ir_rcv_nec_multi_rx_filter.sv
// Input conditioning for the IR receiver: two-flop synchroniser followed by a
// stability filter that only accepts a level change after GLITCH_CYC equal samples.
module ir_rcv_nec_multi_rx_filter #(
  parameter int GLITCH_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [7:0] stable_q;
  logic       level_q;
  logic       rise_q;
  logic       fall_q;

  // Line idles high, so the filtered level starts high to avoid a false falling edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= '0;
      level_q  <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        stable_q <= '0;
      end else if (stable_q == 8'(GLITCH_CYC - 1)) begin
        stable_q <= '0;
        level_q  <= sync_q[1];
        rise_q   <= sync_q[1];
        fall_q   <= ~sync_q[1];
      end else begin
        stable_q <= stable_q + 8'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ir_rcv_nec_multi.sv
// NEC-family IR decoder: tick-based pulse timing, strict or extended addressing,
// repeat tracking with a saturating hold counter and a release timeout.
module ir_rcv_nec_multi #(
  parameter int CLK_FREQ_HZ   = 27000000,
  parameter int GLITCH_CYC    = 16,
  parameter int EXT_ADDR_EN   = 1,
  parameter int RPT_CNT_W     = 8,
  parameter int RELEASE_TICKS = 12000
) (
  input  logic                 clk27,
  input  logic                 reset_n,
  input  logic                 ir_rx,
  output logic [15:0]          ir_addr,
  output logic [7:0]           ir_cmd,
  output logic                 ir_valid,
  output logic                 ir_repeat,
  output logic                 ir_held,
  output logic [RPT_CNT_W-1:0] ir_rpt_cnt,
  output logic                 ir_err
);

  import ir_rcv_nec_multi_pkg::*;

  localparam int TICK_DIV = (CLK_FREQ_HZ / 100000 < 1) ? 1 : CLK_FREQ_HZ / 100000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                 rxLevel, rxRise, rxFall;
  logic [TICK_W-1:0]    tickCnt_q;
  logic                 tick;
  logic [PHASE_W-1:0]   phase_q;
  logic [REL_W-1:0]     relCnt_q;
  logic                 relDone;

  irState_e             state_q, state_d;
  logic [5:0]           bitIdx_q, bitIdx_d;
  logic [31:0]          frame_q, frame_d;
  logic                 rptFlag_q, rptFlag_d;
  logic                 frameOk;
  logic                 evValid, evRepeat, evErr;

  logic [15:0]          addr_q;
  logic [7:0]           cmd_q;
  logic                 valid_q, repeat_q, err_q, held_q;
  logic [RPT_CNT_W-1:0] rptCnt_q;

  ir_rcv_nec_multi_rx_filter #(
    .GLITCH_CYC(GLITCH_CYC)
  ) u_filter (
    .clk_i  (clk27),
    .rst_ni (reset_n),
    .rx_i   (ir_rx),
    .level_o(rxLevel),
    .rise_o (rxRise),
    .fall_o (rxFall)
  );

  assign tick = (tickCnt_q == TICK_W'(TICK_DIV - 1));

  // Free-running tick divider and the edge-to-edge duration counter
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      tickCnt_q <= '0;
      phase_q   <= '0;
    end else begin
      tickCnt_q <= tick ? '0 : tickCnt_q + TICK_W'(1);
      if (rxRise || rxFall) begin
        phase_q <= '0;
      end else if (tick && (phase_q != '1)) begin
        phase_q <= phase_q + 12'd1;
      end
    end
  end

  assign frameOk = (frame_q[23:16] == ~frame_q[31:24]) &&
                   ((EXT_ADDR_EN != 0) || (frame_q[7:0] == ~frame_q[15:8]));

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitIdx_q  <= '0;
      frame_q   <= '0;
      rptFlag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitIdx_q  <= bitIdx_d;
      frame_q   <= frame_d;
      rptFlag_q <= rptFlag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitIdx_d  = bitIdx_q;
    frame_d   = frame_q;
    rptFlag_d = rptFlag_q;
    evValid   = 1'b0;
    evRepeat  = 1'b0;
    evErr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxFall) begin
          state_d   = LEAD_LO;
          bitIdx_d  = '0;
          rptFlag_d = 1'b0;
        end
      end
      LEAD_LO: begin
        if (rxRise) begin
          if (inWindow(phase_q, LEAD_LO_MIN, LEAD_LO_MAX)) begin
            state_d = LEAD_HI;
          end else begin
            evErr   = 1'b1;
            state_d = IDLE;
          end
        end else if (!rxLevel && (phase_q > LEAD_LO_MAX)) begin
          evErr   = 1'b1;
          state_d = IDLE;
        end
      end
      LEAD_HI: begin
        if (rxFall) begin
          if (inWindow(phase_q, LEAD_HI_MIN, LEAD_HI_MAX)) begin
            state_d  = BIT_LO;
            bitIdx_d = '0;
          end else if (inWindow(phase_q, RPT_HI_MIN, RPT_HI_MAX)) begin
            state_d   = BIT_LO;
            rptFlag_d = 1'b1;
          end else begin
            evErr   = 1'b1;
            state_d = IDLE;
          end
        end else if (rxLevel && (phase_q > LEAD_HI_MAX)) begin
          evErr   = 1'b1;
          state_d = IDLE;
        end
      end
      BIT_LO: begin
        // The same burst window closes data bits, the stop burst and the repeat burst
        if (rxRise) begin
          if (!inWindow(phase_q, BURST_MIN, BURST_MAX)) begin
            evErr   = 1'b1;
            state_d = IDLE;
          end else if (rptFlag_q) begin
            evRepeat = held_q;
            state_d  = IDLE;
          end else if (bitIdx_q[5]) begin
            evValid = frameOk;
            evErr   = ~frameOk;
            state_d = IDLE;
          end else begin
            state_d = BIT_HI;
          end
        end
      end
      BIT_HI: begin
        if (rxFall) begin
          if (inWindow(phase_q, SPACE0_MIN, SPACE0_MAX) ||
              inWindow(phase_q, SPACE1_MIN, SPACE1_MAX)) begin
            frame_d[bitIdx_q[4:0]] = inWindow(phase_q, SPACE1_MIN, SPACE1_MAX);
            bitIdx_d = bitIdx_q + 6'd1;
            state_d  = BIT_LO;
          end else begin
            evErr   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign relDone = (relCnt_q == REL_W'(RELEASE_TICKS));

  // Release timer parks at the threshold so hold stays released until the next frame
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      relCnt_q <= '0;
    end else if (evValid || evRepeat) begin
      relCnt_q <= '0;
    end else if (tick && !relDone) begin
      relCnt_q <= relCnt_q + 14'd1;
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      err_q    <= 1'b0;
      held_q   <= 1'b0;
      rptCnt_q <= '0;
    end else begin
      valid_q  <= evValid;
      repeat_q <= evRepeat;
      err_q    <= evErr;
      if (evValid) begin
        addr_q   <= (EXT_ADDR_EN != 0) ? frame_q[15:0] : {8'h00, frame_q[7:0]};
        cmd_q    <= frame_q[23:16];
        held_q   <= 1'b1;
        rptCnt_q <= RPT_CNT_W'(1);
      end else if (evRepeat) begin
        if (rptCnt_q != '1) begin
          rptCnt_q <= rptCnt_q + RPT_CNT_W'(1);
        end
      end else if (relDone) begin
        held_q   <= 1'b0;
        rptCnt_q <= '0;
      end
    end
  end

  assign ir_addr    = addr_q;
  assign ir_cmd     = cmd_q;
  assign ir_valid   = valid_q;
  assign ir_repeat  = repeat_q;
  assign ir_err     = err_q;
  assign ir_held    = held_q;
  assign ir_rpt_cnt = rptCnt_q;

endmodule
